// File: rtl/weight_request_server_pkg.sv
// Shared definitions for the weight request server: layer codes, FSM
// encoding and the bank depth formulas.
package weight_request_server_pkg;

    localparam logic [1:0] LAYER_HIDDEN_2 = 2'b10;
    localparam logic [1:0] LAYER_OUTPUT   = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_SERVE = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Hidden-2 bank: one weight per (node, input) pair, plus one bias per node.
    function automatic int depth_h2(input int n_layer_1, input int n_layer_2);
        return n_layer_2 * (n_layer_1 + 1);
    endfunction

    // Output bank: one weight per (output node, hidden-2 node), plus one bias per node.
    function automatic int depth_out(input int n_layer_2, input int n_output);
        return n_output * (n_layer_2 + 1);
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// Single-write / single-read weight bank with a registered read port.
// A read and a write to the same word in one cycle return the old word.
module weight_bank_ram #(
    parameter int DEPTH      = 99,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Registered read plus write; both sample the array before this edge's update.
    // NOTE: the array has no reset on purpose so it maps onto block RAM; its
    // contents are undefined until loaded, and non-blocking assignments make
    // the read see the pre-write word (read-first).
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[i_rd_addr];
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/weight_request_server.sv
// Weight-memory responder for back_propagation: stores hidden-2 and output
// weights, answers read requests one cycle later, and counts returned error
// beats to detect the end of one backward pass.
module weight_request_server
    import weight_request_server_pkg::*;
#(
    parameter int DATA_WIDTH                    = 32,
    parameter int LAYER_WIDTH                   = 2,
    parameter int WEIGHT_COUNTER_WIDTH          = 11,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
    parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
    parameter int NUMBER_OF_OUTPUT_NODE         = 3,
    parameter int DEPTH_H2  = depth_h2(NUMBER_OF_HIDDEN_NODE_LAYER_1, NUMBER_OF_HIDDEN_NODE_LAYER_2),
    parameter int DEPTH_OUT = depth_out(NUMBER_OF_HIDDEN_NODE_LAYER_2, NUMBER_OF_OUTPUT_NODE),
    parameter int CNT_H2_W  = $clog2(DEPTH_H2 + 1),
    parameter int CNT_OUT_W = $clog2(DEPTH_OUT + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic                            i_load_valid,
    input  logic [LAYER_WIDTH-1:0]          i_load_layer,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_load_addr,
    input  logic [DATA_WIDTH-1:0]           i_load_weight,
    input  logic                            i_weight_valid_request,
    input  logic [LAYER_WIDTH-1:0]          i_weight_layer_request,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr_request,
    output logic                            o_weight_valid,
    output logic [LAYER_WIDTH-1:0]          o_weight_layer,
    output logic [WEIGHT_COUNTER_WIDTH-1:0] o_weight_addr,
    output logic [DATA_WIDTH-1:0]           o_weight,
    input  logic                            i_error_valid,
    input  logic [LAYER_WIDTH-1:0]          i_error_layer,
    input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_error_addr,
    output logic [CNT_H2_W-1:0]             o_err_cnt_h2,
    output logic [CNT_OUT_W-1:0]            o_err_cnt_out,
    output logic [1:0]                      o_state,
    output logic                            o_done,
    output logic                            o_fault
);

    localparam int H2_AW  = $clog2(DEPTH_H2);
    localparam int OUT_AW = $clog2(DEPTH_OUT);

    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] H2_LIMIT  = WEIGHT_COUNTER_WIDTH'(DEPTH_H2);
    localparam logic [WEIGHT_COUNTER_WIDTH-1:0] OUT_LIMIT = WEIGHT_COUNTER_WIDTH'(DEPTH_OUT);
    localparam logic [CNT_H2_W-1:0]             H2_FULL   = CNT_H2_W'(DEPTH_H2);
    localparam logic [CNT_OUT_W-1:0]            OUT_FULL  = CNT_OUT_W'(DEPTH_OUT);

    state_t r_state;
    state_t w_next_state;
    logic   w_clr_cnt;
    logic   r_done;
    logic   r_fault;

    logic                            r_rsp_valid;
    logic                            r_rsp_ok;
    logic [LAYER_WIDTH-1:0]          r_rsp_layer;
    logic [WEIGHT_COUNTER_WIDTH-1:0] r_rsp_addr;

    logic [CNT_H2_W-1:0]  r_cnt_h2;
    logic [CNT_OUT_W-1:0] r_cnt_out;

    logic [DATA_WIDTH-1:0] w_h2_rd_data;
    logic [DATA_WIDTH-1:0] w_out_rd_data;

    // Address/layer qualification for the three input channels.
    logic w_serve;
    logic w_load_h2;
    logic w_load_out;
    logic w_load_bad;
    logic w_req_ok;
    logic w_req_fault;
    logic w_err_h2;
    logic w_err_out;
    logic w_err_fault;

    assign w_serve = (r_state == ST_SERVE);

    assign w_load_h2  = i_load_valid && (i_load_layer == LAYER_HIDDEN_2) && (i_load_addr < H2_LIMIT);
    assign w_load_out = i_load_valid && (i_load_layer == LAYER_OUTPUT)   && (i_load_addr < OUT_LIMIT);
    assign w_load_bad = i_load_valid && !(w_load_h2 || w_load_out);

    assign w_req_ok = ((i_weight_layer_request == LAYER_HIDDEN_2) && (i_weight_addr_request < H2_LIMIT)) ||
                      ((i_weight_layer_request == LAYER_OUTPUT)   && (i_weight_addr_request < OUT_LIMIT));
    assign w_req_fault = i_weight_valid_request && !(w_serve && w_req_ok);

    assign w_err_h2    = i_error_valid && w_serve && (i_error_layer == LAYER_HIDDEN_2) && (i_error_addr < H2_LIMIT);
    assign w_err_out   = i_error_valid && w_serve && (i_error_layer == LAYER_OUTPUT)   && (i_error_addr < OUT_LIMIT);
    assign w_err_fault = i_error_valid && !(w_err_h2 || w_err_out);

    // Two weight banks; writes are accepted in any state once qualified.
    weight_bank_ram #(
        .DEPTH      (DEPTH_H2),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (H2_AW)
    ) u_bank_h2 (
        .clk       (clk),
        .i_wr_en   (w_load_h2),
        .i_wr_addr (i_load_addr[H2_AW-1:0]),
        .i_wr_data (i_load_weight),
        .i_rd_addr (i_weight_addr_request[H2_AW-1:0]),
        .o_rd_data (w_h2_rd_data)
    );

    weight_bank_ram #(
        .DEPTH      (DEPTH_OUT),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (OUT_AW)
    ) u_bank_out (
        .clk       (clk),
        .i_wr_en   (w_load_out),
        .i_wr_addr (i_load_addr[OUT_AW-1:0]),
        .i_wr_data (i_load_weight),
        .i_rd_addr (i_weight_addr_request[OUT_AW-1:0]),
        .o_rd_data (w_out_rd_data)
    );

    // Next-state decode: LOAD -> SERVE on start, SERVE -> DONE on full counts, DONE -> LOAD on start.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_clr_cnt    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (i_start) begin
                    w_next_state = ST_SERVE;
                    w_clr_cnt    = 1'b1;
                end
            end
            ST_SERVE: begin
                if ((r_cnt_h2 == H2_FULL) && (r_cnt_out == OUT_FULL)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_start) begin
                    w_next_state = ST_LOAD;
                end
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    // State register and the completion pulse, which rises together with DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == ST_SERVE) && (w_next_state == ST_DONE);
        end
    end

    // Response pipeline: one stage aligned with the bank read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_ok    <= 1'b0;
            r_rsp_layer <= '0;
            r_rsp_addr  <= '0;
        end else begin
            r_rsp_valid <= i_weight_valid_request && w_serve;
            r_rsp_ok    <= i_weight_valid_request && w_serve && w_req_ok;
            if (i_weight_valid_request && w_serve) begin
                r_rsp_layer <= i_weight_layer_request;
                r_rsp_addr  <= i_weight_addr_request;
            end else begin
                r_rsp_layer <= '0;
                r_rsp_addr  <= '0;
            end
        end
    end

    // Saturating error-beat counters, cleared when a new pass starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_h2  <= '0;
            r_cnt_out <= '0;
        end else if (w_clr_cnt) begin
            r_cnt_h2  <= '0;
            r_cnt_out <= '0;
        end else begin
            if (w_err_h2 && (r_cnt_h2 != H2_FULL)) begin
                r_cnt_h2 <= r_cnt_h2 + 1'b1;
            end
            if (w_err_out && (r_cnt_out != OUT_FULL)) begin
                r_cnt_out <= r_cnt_out + 1'b1;
            end
        end
    end

    // Sticky protocol fault, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_load_bad || w_req_fault || w_err_fault) begin
            r_fault <= 1'b1;
        end
    end

    assign o_weight_valid = r_rsp_valid;
    assign o_weight_layer = r_rsp_layer;
    assign o_weight_addr  = r_rsp_addr;
    // Invalid or idle responses carry zero instead of whatever the bank read.
    assign o_weight       = !r_rsp_ok ? '0 :
                            (r_rsp_layer == LAYER_OUTPUT) ? w_out_rd_data : w_h2_rd_data;
    assign o_err_cnt_h2   = r_cnt_h2;
    assign o_err_cnt_out  = r_cnt_out;
    assign o_state        = r_state;
    assign o_done         = r_done;
    assign o_fault        = r_fault;

endmodule

// File: tb/tb_weight_request_server.sv
// Directed testbench for weight_request_server.
module tb_weight_request_server;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_load_valid;
    logic [1:0]  i_load_layer;
    logic [10:0] i_load_addr;
    logic [31:0] i_load_weight;
    logic        i_weight_valid_request;
    logic [1:0]  i_weight_layer_request;
    logic [10:0] i_weight_addr_request;
    logic        o_weight_valid;
    logic [1:0]  o_weight_layer;
    logic [10:0] o_weight_addr;
    logic [31:0] o_weight;
    logic        i_error_valid;
    logic [1:0]  i_error_layer;
    logic [10:0] i_error_addr;
    logic [10:0] o_err_cnt_h2;
    logic [6:0]  o_err_cnt_out;
    logic [1:0]  o_state;
    logic        o_done;
    logic        o_fault;

    int pass_cnt  = 0;
    int total_cnt = 0;

    weight_request_server dut (
        .clk                    (clk),
        .rst                    (rst),
        .i_start                (i_start),
        .i_load_valid           (i_load_valid),
        .i_load_layer           (i_load_layer),
        .i_load_addr            (i_load_addr),
        .i_load_weight          (i_load_weight),
        .i_weight_valid_request (i_weight_valid_request),
        .i_weight_layer_request (i_weight_layer_request),
        .i_weight_addr_request  (i_weight_addr_request),
        .o_weight_valid         (o_weight_valid),
        .o_weight_layer         (o_weight_layer),
        .o_weight_addr          (o_weight_addr),
        .o_weight               (o_weight),
        .i_error_valid          (i_error_valid),
        .i_error_layer          (i_error_layer),
        .i_error_addr           (i_error_addr),
        .o_err_cnt_h2           (o_err_cnt_h2),
        .o_err_cnt_out          (o_err_cnt_out),
        .o_state                (o_state),
        .o_done                 (o_done),
        .o_fault                (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] layer, input logic [10:0] addr, input logic [31:0] data);
        i_load_valid  = 1'b1;
        i_load_layer  = layer;
        i_load_addr   = addr;
        i_load_weight = data;
        tick();
        i_load_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        total_cnt++; if (o_state !== 2'b00) $display("FAIL reset_state: got %0h want 0", o_state); else pass_cnt++;
        total_cnt++; if (o_weight_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", o_weight_valid); else pass_cnt++;
        total_cnt++; if (o_weight !== 32'h0) $display("FAIL reset_weight: got %08h want 0", o_weight); else pass_cnt++;
        total_cnt++; if (o_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", o_done); else pass_cnt++;
        total_cnt++; if (o_fault !== 1'b0) $display("FAIL reset_fault: got %0b want 0", o_fault); else pass_cnt++;
        total_cnt++; if (o_err_cnt_h2 !== 11'd0 || o_err_cnt_out !== 7'd0)
            $display("FAIL reset_counts: got %0d/%0d want 0/0", o_err_cnt_h2, o_err_cnt_out); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_and_serve();
        do_load(2'b11, 11'd5, 32'h3F80_0000);
        do_load(2'b11, 11'd7, 32'h3F80_0000);
        do_load(2'b10, 11'd1055, 32'hBF00_0000);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        total_cnt++; if (o_state !== 2'b01) $display("FAIL serve_state: got %0h want 1", o_state); else pass_cnt++;
        i_weight_valid_request = 1'b1;
        i_weight_layer_request = 2'b11;
        i_weight_addr_request  = 11'd5;
        tick();
        total_cnt++; if (o_weight_valid !== 1'b1 || o_weight_layer !== 2'b11 || o_weight_addr !== 11'd5 || o_weight !== 32'h3F80_0000)
            $display("FAIL rsp_out5: got v=%0b l=%0h a=%0d w=%08h want v=1 l=3 a=5 w=3f800000",
                     o_weight_valid, o_weight_layer, o_weight_addr, o_weight); else pass_cnt++;
        i_weight_layer_request = 2'b10;
        i_weight_addr_request  = 11'd1055;
        tick();
        total_cnt++; if (o_weight_valid !== 1'b1 || o_weight_layer !== 2'b10 || o_weight_addr !== 11'd1055 || o_weight !== 32'hBF00_0000)
            $display("FAIL rsp_h2_1055: got v=%0b l=%0h a=%0d w=%08h want v=1 l=2 a=1055 w=bf000000",
                     o_weight_valid, o_weight_layer, o_weight_addr, o_weight); else pass_cnt++;
        i_weight_valid_request = 1'b0;
        tick();
        total_cnt++; if (o_weight_valid !== 1'b0) $display("FAIL rsp_idle: got %0b want 0", o_weight_valid); else pass_cnt++;
        total_cnt++; if (o_fault !== 1'b0) $display("FAIL fault_clean: got %0b want 0", o_fault); else pass_cnt++;
    endtask

    task automatic test_invalid_requests();
        i_weight_valid_request = 1'b1;
        i_weight_layer_request = 2'b10;
        i_weight_addr_request  = 11'd1056;
        tick();
        total_cnt++; if (o_weight_valid !== 1'b1 || o_weight_addr !== 11'd1056 || o_weight !== 32'h0)
            $display("FAIL rsp_h2_oob: got v=%0b a=%0d w=%08h want v=1 a=1056 w=0",
                     o_weight_valid, o_weight_addr, o_weight); else pass_cnt++;
        i_weight_layer_request = 2'b01;
        i_weight_addr_request  = 11'd0;
        tick();
        total_cnt++; if (o_weight_valid !== 1'b1 || o_weight_layer !== 2'b01 || o_weight !== 32'h0)
            $display("FAIL rsp_bad_layer: got v=%0b l=%0h w=%08h want v=1 l=1 w=0",
                     o_weight_valid, o_weight_layer, o_weight); else pass_cnt++;
        i_weight_valid_request = 1'b0;
        tick();
        total_cnt++; if (o_fault !== 1'b1) $display("FAIL fault_bad_req: got %0b want 1", o_fault); else pass_cnt++;
    endtask

    task automatic test_read_first();
        i_load_valid           = 1'b1;
        i_load_layer           = 2'b11;
        i_load_addr            = 11'd7;
        i_load_weight          = 32'h4000_0000;
        i_weight_valid_request = 1'b1;
        i_weight_layer_request = 2'b11;
        i_weight_addr_request  = 11'd7;
        tick();
        i_load_valid = 1'b0;
        total_cnt++; if (o_weight !== 32'h3F80_0000) $display("FAIL read_first_old: got %08h want 3f800000", o_weight); else pass_cnt++;
        tick();
        total_cnt++; if (o_weight !== 32'h4000_0000) $display("FAIL read_first_new: got %08h want 40000000", o_weight); else pass_cnt++;
        i_weight_valid_request = 1'b0;
        tick();
    endtask

    task automatic test_start_in_serve();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        total_cnt++; if (o_state !== 2'b01) $display("FAIL start_ignored: got %0h want 1", o_state); else pass_cnt++;
    endtask

    task automatic test_error_stream();
        int done_pulses = 0;
        i_error_valid = 1'b1;
        i_error_layer = 2'b11;
        for (int i = 0; i < 99; i++) begin
            i_error_addr = 11'(i);
            tick();
            if (o_done) done_pulses++;
        end
        // Two beats that must not be counted: bad layer, and output address past depth.
        i_error_layer = 2'b01; i_error_addr = 11'd0;
        tick();
        i_error_layer = 2'b11; i_error_addr = 11'd99;
        tick();
        i_error_layer = 2'b10;
        for (int i = 0; i < 1055; i++) begin
            i_error_addr = 11'(i);
            tick();
            if (o_done) done_pulses++;
        end
        total_cnt++; if (o_err_cnt_h2 !== 11'd1055 || o_err_cnt_out !== 7'd99 || o_state !== 2'b01)
            $display("FAIL pre_done: got h2=%0d out=%0d st=%0h want 1055/99/1",
                     o_err_cnt_h2, o_err_cnt_out, o_state); else pass_cnt++;
        i_error_addr = 11'd1055;
        tick();
        i_error_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (o_done) done_pulses++;
        end
        total_cnt++; if (done_pulses != 1) $display("FAIL done_pulses: got %0d want 1", done_pulses); else pass_cnt++;
        total_cnt++; if (o_state !== 2'b10) $display("FAIL done_state: got %0h want 2", o_state); else pass_cnt++;
        total_cnt++; if (o_err_cnt_h2 !== 11'd1056 || o_err_cnt_out !== 7'd99)
            $display("FAIL done_counts: got %0d/%0d want 1056/99", o_err_cnt_h2, o_err_cnt_out); else pass_cnt++;
        i_error_valid = 1'b1; i_error_layer = 2'b11; i_error_addr = 11'd0;
        tick();
        i_error_valid = 1'b0;
        tick();
        total_cnt++; if (o_err_cnt_out !== 7'd99) $display("FAIL beat_in_done: got %0d want 99", o_err_cnt_out); else pass_cnt++;
    endtask

    task automatic test_done_to_load();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        total_cnt++; if (o_state !== 2'b00 || o_err_cnt_h2 !== 11'd1056 || o_err_cnt_out !== 7'd99)
            $display("FAIL back_to_load: got st=%0h h2=%0d out=%0d want 0/1056/99",
                     o_state, o_err_cnt_h2, o_err_cnt_out); else pass_cnt++;
        i_weight_valid_request = 1'b1; i_weight_layer_request = 2'b11; i_weight_addr_request = 11'd5;
        tick();
        i_weight_valid_request = 1'b0;
        total_cnt++; if (o_weight_valid !== 1'b0) $display("FAIL req_in_load: got %0b want 0", o_weight_valid); else pass_cnt++;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        total_cnt++; if (o_state !== 2'b01 || o_err_cnt_h2 !== 11'd0 || o_err_cnt_out !== 7'd0)
            $display("FAIL restart_clear: got st=%0h h2=%0d out=%0d want 1/0/0",
                     o_state, o_err_cnt_h2, o_err_cnt_out); else pass_cnt++;
    endtask

    task automatic test_reset_mid_serve();
        i_weight_valid_request = 1'b1; i_weight_layer_request = 2'b11; i_weight_addr_request = 11'd5;
        tick();
        total_cnt++; if (o_weight_valid !== 1'b1 || o_weight !== 32'h3F80_0000)
            $display("FAIL pre_reset_rsp: got v=%0b w=%08h want v=1 w=3f800000", o_weight_valid, o_weight); else pass_cnt++;
        i_weight_addr_request = 11'd7;
        rst = 1'b1;
        #1;
        total_cnt++; if (o_weight_valid !== 1'b0 || o_state !== 2'b00 || o_fault !== 1'b0)
            $display("FAIL async_reset: got v=%0b st=%0h f=%0b want 0/0/0", o_weight_valid, o_state, o_fault); else pass_cnt++;
        tick();
        i_weight_valid_request = 1'b0;
        rst = 1'b0;
        tick();
        total_cnt++; if (o_weight_valid !== 1'b0 || o_state !== 2'b00)
            $display("FAIL post_reset: got v=%0b st=%0h want 0/0", o_weight_valid, o_state); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_load_valid = 1'b0; i_load_layer = 2'b00; i_load_addr = '0; i_load_weight = '0;
        i_weight_valid_request = 1'b0; i_weight_layer_request = 2'b00; i_weight_addr_request = '0;
        i_error_valid = 1'b0; i_error_layer = 2'b00; i_error_addr = '0;
        test_reset();
        test_load_and_serve();
        test_invalid_requests();
        test_read_first();
        test_start_in_serve();
        test_error_stream();
        test_done_to_load();
        test_reset_mid_serve();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time bound so a stuck run still terminates.
    initial begin
        #1_000_000;
        $display("FAIL timeout: run exceeded time bound");
        $fatal(1);
    end

endmodule
